o_result_collector: RTL and testbench
=====================================

O_RESULT_COLLECTOR -- requirements
Module: o_result_collector

Interface
REQ-001 SHALL have parameter N_CH, default 9, meaning number of input channels (systolic rows or columns).
REQ-002 SHALL have parameter W_IN, default 32, meaning input accumulator width, two's complement.
REQ-003 SHALL have parameter W_OUT, default 8, meaning output word width.
REQ-004 SHALL have parameter DEPTH, default 16, meaning per-channel FIFO depth, power of two, at least 2.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_data, input, N_CH*W_IN bits: channel k occupies bits [k*W_IN +: W_IN].
REQ-008 SHALL have port i_valid, input, N_CH bits: per-channel write strobe.
REQ-009 SHALL have port i_relu_en, input, 1 bit: 1 selects ReLU clamp, 0 selects signed saturate.
REQ-010 SHALL have port i_clr_err, input, 1 bit: clears the sticky overflow flags.
REQ-011 SHALL have port o_data, output, W_OUT bits: collected result word.
REQ-012 SHALL have port o_ch_id, output, $clog2(N_CH) bits: source channel of o_data.
REQ-013 SHALL have port o_valid, output, 1 bit: o_data and o_ch_id are valid.
REQ-014 SHALL have port i_ready, input, 1 bit: downstream accepts the word when o_valid && i_ready.
REQ-015 SHALL have port o_overflow, output, N_CH bits: sticky per-channel drop flag.
REQ-016 SHALL have port o_busy, output, 1 bit: high when any FIFO or the output register holds data.

Function
REQ-017 SHALL convert each input at write time:
- ReLU mode: negative values become 0; values above 2^W_OUT-1 become 2^W_OUT-1.
- Saturate mode: clamp to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
REQ-018 SHALL store converted words in one FIFO per channel, DEPTH entries each, with pointers that wrap modulo DEPTH.
REQ-019 SHALL drop a write to a full FIFO and set o_overflow[k], except when that FIFO is read in the same cycle, in which case the write is accepted.
REQ-020 SHALL hold o_overflow[k] until i_rst or i_clr_err; when i_clr_err coincides with a new drop, the flag SHALL read 1.
REQ-021 SHALL select the next non-empty channel round-robin, starting one above the last served channel, wrapping from N_CH-1 to 0, with no idle cycles for empty channels.
REQ-022 SHALL use a 2-state FSM:
- IDLE: o_valid=0.
- HOLD: o_valid=1.
REQ-023 SHALL go from IDLE to HOLD on the cycle after any FIFO becomes non-empty, loading the output register with the popped word (1-cycle latency from write to o_valid).
REQ-024 SHALL keep o_data and o_ch_id stable in HOLD while i_ready=0.
REQ-025 SHALL, on a handshake in HOLD, pop the next word in the same cycle if one exists and stay in HOLD (one word per cycle sustained); otherwise it SHALL return to IDLE.
REQ-026 SHALL accept a write to an empty FIFO in the same cycle as a pop from another channel.
REQ-027 SHALL NOT let a change of i_relu_en alter words already stored.

Reset
REQ-028 SHALL, while i_rst=1, asynchronously clear all FIFO pointers and counts, set the round-robin pointer to N_CH-1 (so channel 0 is served first), and put the FSM in IDLE.
REQ-029 SHALL drive o_valid=0, o_data=0, o_ch_id=0, o_overflow=0 and o_busy=0 during reset.
REQ-030 SHALL discard all buffered data on a reset mid-operation, with no partial word emitted after release.

Structure
REQ-031 SHALL place the saturation bound constants and the conversion function in shared package o_collect_pkg.
REQ-032 SHALL implement each channel FIFO as sub-module o_ch_fifo (parameters W_OUT and DEPTH; outputs empty, full, data), instantiated N_CH times by a generate loop.

Verification
REQ-033 SHALL cover ReLU conversion: with N_CH=9, i_relu_en=1, write -5, 100 and 300 to channel 0 -> o_data equals 0, 100, 255 in order, o_ch_id=0.
REQ-034 SHALL cover signed saturation: i_relu_en=0, write -200 and 127 -> o_data equals 0x80, then 0x7F.
REQ-035 SHALL cover round-robin order: write to channels 2, 5 and 8 in one cycle with i_ready=1 -> o_ch_id sequence 2, 5, 8 on consecutive cycles, then o_valid=0.
REQ-036 SHALL cover overflow and backpressure: i_ready=0, 17 writes to channel 3 with DEPTH=16 -> o_overflow[3]=1 and o_data stable; then i_ready=1 -> exactly 16 words drain in order, and o_overflow[3] clears only after i_clr_err.
REQ-037 SHALL cover reset mid-operation: assert i_rst with 4 words buffered -> o_valid=0 and o_busy=0 immediately; after release, the first write to channel 0 appears after 1 cycle.

Source files
------------

// File: rtl/o_collect_pkg.sv
// Shared types, saturation bounds and the write-time word conversion
// used by the result collector and its channel FIFOs.
package o_collect_pkg;

  localparam int W_MAX_IN  = 64;
  localparam int W_MAX_OUT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic signed [W_MAX_IN-1:0] wide_t;

  function automatic wide_t relu_hi(input int unsigned w);
    return (wide_t'(1) <<< w) - wide_t'(1);
  endfunction

  function automatic wide_t sat_hi(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_lo(input int unsigned w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Clamp x into the range of a w-bit output word, unsigned or signed.
  function automatic logic [W_MAX_OUT-1:0] convert(
    input wide_t       x,
    input logic        relu,
    input int unsigned w
  );
    wide_t hi;
    wide_t lo;
    wide_t y;
    hi = relu ? relu_hi(w) : sat_hi(w);
    lo = relu ? '0 : sat_lo(w);
    if (x > hi)
      y = hi;
    else if (x < lo)
      y = lo;
    else
      y = x;
    return y[W_MAX_OUT-1:0];
  endfunction

endpackage

// File: rtl/o_ch_fifo.sv
// Per-channel result FIFO; a popped word keeps its slot reserved
// until the downstream handshake frees it.
module o_ch_fifo
  import o_collect_pkg::*;
#(
  parameter int W_OUT = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W_OUT-1:0] din,
  input  logic             pop,
  input  logic             free,
  output logic             empty,
  output logic             full,
  output logic [W_OUT-1:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [W_OUT-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      used;
  logic [AW:0]      avail;

  assign empty = (avail == '0);
  assign full  = (used == (AW+1)'(DEPTH));
  assign data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      avail  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, free})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
      unique case ({push, pop})
        2'b10:   avail <= avail + 1'b1;
        2'b01:   avail <= avail - 1'b1;
        default: avail <= avail;
      endcase
    end
  end

endmodule

// File: rtl/o_result_collector.sv
// Collects converted accumulator results from N_CH channels and
// serialises them round-robin onto one valid/ready output.
module o_result_collector
  import o_collect_pkg::*;
#(
  parameter int N_CH  = 9,
  parameter int W_IN  = 32,
  parameter int W_OUT = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH*W_IN-1:0]     i_data,
  input  logic [N_CH-1:0]          i_valid,
  input  logic                     i_relu_en,
  input  logic                     i_clr_err,
  output logic [W_OUT-1:0]         o_data,
  output logic [$clog2(N_CH)-1:0]  o_ch_id,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [N_CH-1:0]          o_overflow,
  output logic                     o_busy
);

  localparam int CW = $clog2(N_CH);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    rr;
  logic [CW-1:0]    sel;
  logic [CW-1:0]    out_ch;
  logic [W_OUT-1:0] out_data;
  logic [N_CH-1:0]  empty;
  logic [N_CH-1:0]  full;
  logic [N_CH-1:0]  push;
  logic [N_CH-1:0]  pop;
  logic [N_CH-1:0]  free;
  logic [N_CH-1:0]  drop;
  logic [N_CH-1:0]  ovf;
  logic [W_OUT-1:0] fifo_data [N_CH];
  logic             found;
  logic             hs;
  logic             load;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic signed [W_IN-1:0] raw;
    logic [W_OUT-1:0]       cv;

    assign raw = i_data[k*W_IN +: W_IN];
    assign cv  = W_OUT'(convert(wide_t'(raw), i_relu_en, W_OUT));

    o_ch_fifo #(
      .W_OUT (W_OUT),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push[k]),
      .din   (cv),
      .pop   (pop[k]),
      .free  (free[k]),
      .empty (empty[k]),
      .full  (full[k]),
      .data  (fifo_data[k])
    );
  end

  assign hs = (state == HOLD) && i_ready;

  // First non-empty channel strictly after the last one served.
  always_comb begin : arb
    int j;
    j     = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      j = int'(rr) + i;
      if (j >= N_CH)
        j = j - N_CH;
      if (!found && !empty[j]) begin
        found = 1'b1;
        sel   = CW'(j);
      end
    end
  end

  assign load = found && ((state == IDLE) || hs);

  always_comb begin
    state_nx = state;
    free     = '0;
    pop      = '0;
    if (hs)
      free[out_ch] = 1'b1;
    if (load)
      pop[sel] = 1'b1;
    unique case (state)
      IDLE: if (found) state_nx = HOLD;
      HOLD: if (i_ready && !found) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign push = i_valid & (~full | free);
  assign drop = i_valid & full & ~free;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      rr       <= CW'(N_CH - 1);
      out_data <= '0;
      out_ch   <= '0;
      ovf      <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_data <= fifo_data[sel];
        out_ch   <= sel;
        rr       <= sel;
      end
      ovf <= i_clr_err ? drop : (ovf | drop);
    end
  end

  assign o_data     = out_data;
  assign o_ch_id    = out_ch;
  assign o_valid    = (state == HOLD);
  assign o_overflow = ovf;
  assign o_busy     = (state == HOLD) || !(&empty);

endmodule

// File: tb/tb_o_result_collector.sv
// Directed testbench for o_result_collector: conversion, round-robin,
// overflow with backpressure, slot reuse and reset mid-operation.
module tb_o_result_collector;

  localparam int N_CH  = 9;
  localparam int W_IN  = 32;
  localparam int W_OUT = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(N_CH);

  logic                 clk;
  logic                 i_rst;
  logic [N_CH*W_IN-1:0] i_data;
  logic [N_CH-1:0]      i_valid;
  logic                 i_relu_en;
  logic                 i_clr_err;
  logic [W_OUT-1:0]     o_data;
  logic [CW-1:0]        o_ch_id;
  logic                 o_valid;
  logic                 i_ready;
  logic [N_CH-1:0]      o_overflow;
  logic                 o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  o_result_collector #(
    .N_CH  (N_CH),
    .W_IN  (W_IN),
    .W_OUT (W_OUT),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_relu_en  (i_relu_en),
    .i_clr_err  (i_clr_err),
    .o_data     (o_data),
    .o_ch_id    (o_ch_id),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input int val);
    i_data = '0;
    i_data[ch*W_IN +: W_IN] = val;
    i_valid = '0;
    i_valid[ch] = 1'b1;
    tick();
    i_valid = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #2;
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b want=0", o_valid);
    end
    n_checks++;
    if (o_data !== 8'h00 || o_ch_id !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h/%0d want=00/0", o_data, o_ch_id);
    end
    n_checks++;
    if (o_overflow !== '0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags ovf=%h busy=%b want=0/0", o_overflow, o_busy);
    end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_relu();
    logic [7:0] exp [3];
    exp[0] = 8'd0; exp[1] = 8'd100; exp[2] = 8'd255;
    i_ready = 1'b0;
    i_relu_en = 1'b1;
    put(0, -5);
    put(0, 100);
    put(0, 300);
    // stored words must not follow the mode change
    i_relu_en = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== exp[i] || o_ch_id !== 4'd0) begin
        n_fail++;
        $display("FAIL relu_w%0d got v=%b d=%0d ch=%0d want v=1 d=%0d ch=0",
                 i, o_valid, o_data, o_ch_id, exp[i]);
      end
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL relu_idle got=%b want=0", o_valid);
    end
  endtask

  task automatic test_sat();
    logic [7:0] exp [2];
    exp[0] = 8'h80; exp[1] = 8'h7F;
    i_ready = 1'b0;
    i_relu_en = 1'b0;
    put(1, -200);
    put(1, 127);
    i_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== exp[i] || o_ch_id !== 4'd1) begin
        n_fail++;
        $display("FAIL sat_w%0d got v=%b d=%h ch=%0d want v=1 d=%h ch=1",
                 i, o_valid, o_data, o_ch_id, exp[i]);
      end
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL sat_idle got=%b want=0", o_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ech [3];
    logic [7:0] ed [3];
    ech[0] = 4'd2; ech[1] = 4'd5; ech[2] = 4'd8;
    ed[0] = 8'd10; ed[1] = 8'd20; ed[2] = 8'd30;
    i_ready = 1'b1;
    i_relu_en = 1'b0;
    i_data = '0;
    i_data[2*W_IN +: W_IN] = 10;
    i_data[5*W_IN +: W_IN] = 20;
    i_data[8*W_IN +: W_IN] = 30;
    i_valid = 9'b100100100;
    tick();
    i_valid = '0;
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_latency got=%b want=0", o_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_ch_id !== ech[i] || o_data !== ed[i]) begin
        n_fail++;
        $display("FAIL rr_w%0d got v=%b ch=%0d d=%0d want v=1 ch=%0d d=%0d",
                 i, o_valid, o_ch_id, o_data, ech[i], ed[i]);
      end
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle got v=%b busy=%b want 0/0", o_valid, o_busy);
    end
  endtask

  task automatic test_overflow();
    i_ready = 1'b0;
    i_relu_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      put(3, i);
    n_checks++;
    if (o_overflow !== 9'h008) begin
      n_fail++; $display("FAIL ovf_set got=%h want=008", o_overflow);
    end
    tick();
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'd0 || o_ch_id !== 4'd3) begin
      n_fail++;
      $display("FAIL ovf_hold got v=%b d=%0d ch=%0d want v=1 d=0 ch=3",
               o_valid, o_data, o_ch_id);
    end
    i_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== 8'(i) || o_ch_id !== 4'd3) begin
        n_fail++;
        $display("FAIL ovf_drain_w%0d got v=%b d=%0d ch=%0d want v=1 d=%0d ch=3",
                 i, o_valid, o_data, o_ch_id, i);
      end
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b0 || o_overflow !== 9'h008) begin
      n_fail++;
      $display("FAIL ovf_after_drain got v=%b ovf=%h want v=0 ovf=008", o_valid, o_overflow);
    end
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    n_checks++;
    if (o_overflow !== '0) begin
      n_fail++; $display("FAIL ovf_clear got=%h want=000", o_overflow);
    end
  endtask

  task automatic test_full_read();
    logic [7:0] e;
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      put(6, i);
    // channel full; the handshake frees a slot in the same cycle
    i_ready = 1'b1;
    put(6, 99);
    for (int i = 0; i < DEPTH; i++) begin
      e = (i < DEPTH - 1) ? 8'(i + 1) : 8'd99;
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== e || o_ch_id !== 4'd6) begin
        n_fail++;
        $display("FAIL fullrd_w%0d got v=%b d=%0d ch=%0d want v=1 d=%0d ch=6",
                 i, o_valid, o_data, o_ch_id, e);
      end
      tick();
    end
    n_checks++;
    if (o_valid !== 1'b0 || o_overflow !== '0) begin
      n_fail++;
      $display("FAIL fullrd_end got v=%b ovf=%h want v=0 ovf=000", o_valid, o_overflow);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    put(0, 1);
    put(0, 2);
    put(0, 3);
    put(0, 4);
    n_checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got v=%b busy=%b want 1/1", o_valid, o_busy);
    end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_rst got v=%b busy=%b d=%0d want 0/0/0", o_valid, o_busy, o_data);
    end
    tick();
    i_rst = 1'b0;
    i_ready = 1'b1;
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_release got=%b want=0", o_valid);
    end
    put(0, 42);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_lat0 got=%b want=0", o_valid);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'd42 || o_ch_id !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_first got v=%b d=%0d ch=%0d want v=1 d=42 ch=0",
               o_valid, o_data, o_ch_id);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_end got v=%b busy=%b want 0/0", o_valid, o_busy);
    end
  endtask

  initial begin
    i_rst     = 1'b0;
    i_data    = '0;
    i_valid   = '0;
    i_relu_en = 1'b0;
    i_clr_err = 1'b0;
    i_ready   = 1'b0;
    test_reset();
    test_relu();
    test_sat();
    test_round_robin();
    test_overflow();
    test_full_read();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
